// File: rtl/cordic_ln_sequencer.sv
// rtl/cordic_ln_sequencer.sv - control sequencer for a hyperbolic CORDIC natural-log datapath
module cordic_ln_sequencer #(
  parameter int ITER_N = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beg,
  input  logic       ack,
  output logic       mux_sel,
  output logic       load_en,
  output logic [4:0] iter_idx,
  output logic       out_en,
  output logic       ready,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(ITER_N);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] idx;
  logic       rpt_pend;
  logic       rpt_here;
  logic       last_step;

  // Indices 4 and 13 are visited twice for hyperbolic convergence; 13 only if the run reaches it.
  assign rpt_here  = (idx == 5'd4) || ((ITER_N >= 13) && (idx == 5'd13));
  // The final step is index ITER_N, on its second visit if that index repeats.
  assign last_step = (idx == LAST_IDX) && (!rpt_here || rpt_pend);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter and repeat flag; rpt_pend marks the second visit of a repeated index.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 5'd0;
      rpt_pend <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          idx      <= 5'd1;
          rpt_pend <= 1'b0;
        end
        S_ITER: begin
          if (!last_step) begin
            if (rpt_here && !rpt_pend) begin
              rpt_pend <= 1'b1;
            end else begin
              rpt_pend <= 1'b0;
              idx      <= idx + 5'd1;
            end
          end
        end
        S_POST: begin
          idx      <= idx;
          rpt_pend <= 1'b0;
        end
        default: begin
          idx      <= 5'd0;
          rpt_pend <= 1'b0;
        end
      endcase
    end
  end

  // Next-state decode; beg only counts in IDLE and ack only in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (beg) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ITER;
      S_ITER:  if (last_step) state_nxt = S_POST;
      S_POST:  state_nxt = S_DONE;
      S_DONE:  if (ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode purely from registered state and counter.
  always_comb begin
    mux_sel  = 1'b0;
    load_en  = 1'b0;
    iter_idx = 5'd0;
    out_en   = 1'b0;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_LOAD: begin
        load_en  = 1'b1;
        iter_idx = 5'd1;
      end
      S_ITER: begin
        mux_sel  = 1'b1;
        load_en  = 1'b1;
        iter_idx = idx;
      end
      S_POST: begin
        mux_sel  = 1'b1;
        out_en   = 1'b1;
        iter_idx = idx;
      end
      S_DONE: done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cordic_ln_sequencer.sv
// tb/tb_cordic_ln_sequencer.sv - scoreboard testbench for cordic_ln_sequencer
module tb_cordic_ln_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] beg;
  logic [2:0] ack;
  logic [2:0] mux_sel;
  logic [2:0] load_en;
  logic [2:0] out_en;
  logic [2:0] ready;
  logic [2:0] done;
  logic [4:0] iter_idx [3];

  int tests;
  int fails;
  int cyc;
  int iter_cnt [3];
  logic [2:0] done_prev;

  // kind 0: LOAD/ITER step, val = {mux_sel, iter_idx}; kind 1: out_en cycle; kind 2: done rise cycle
  typedef struct {
    int inst;
    int kind;
    int val;
  } rec_t;
  rec_t sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cordic_ln_sequencer #(.ITER_N(g == 0 ? 15 : (g == 1 ? 4 : 12))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .beg      (beg[g]),
      .ack      (ack[g]),
      .mux_sel  (mux_sel[g]),
      .load_en  (load_en[g]),
      .iter_idx (iter_idx[g]),
      .out_en   (out_en[g]),
      .ready    (ready[g]),
      .done     (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_of(input int g);
    return (g == 0) ? 15 : ((g == 1) ? 4 : 12);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int find_rec(input int g, input int k);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].inst == g && sb[i].kind == k) return i;
    end
    return -1;
  endfunction

  // Monitor: pops the expected record whenever an instance presents a step, capture or done.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int k;
      if (load_en[g]) begin
        k = find_rec(g, 0);
        if (k < 0) begin
          check($sformatf("unexpected_step[%0d]", g), 1, 0);
        end else begin
          check($sformatf("step[%0d]", g), {26'd0, mux_sel[g], iter_idx[g]}, sb[k].val);
          sb.delete(k);
        end
        if (mux_sel[g]) iter_cnt[g]++;
      end
      if (out_en[g]) begin
        k = find_rec(g, 1);
        if (k < 0) begin
          check($sformatf("unexpected_out_en[%0d]", g), 1, 0);
        end else begin
          check($sformatf("out_en_cycle[%0d]", g), cyc, sb[k].val);
          check($sformatf("post_idx[%0d]", g), int'(iter_idx[g]), n_of(g));
          check($sformatf("post_load_en[%0d]", g), int'(load_en[g]), 0);
          sb.delete(k);
        end
      end
      if (done[g] && !done_prev[g]) begin
        k = find_rec(g, 2);
        if (k < 0) begin
          check($sformatf("unexpected_done[%0d]", g), 1, 0);
        end else begin
          check($sformatf("done_cycle[%0d]", g), cyc, sb[k].val);
          sb.delete(k);
        end
      end
    end
    done_prev <= done;
  end

  // Issue beg (called #1 after an edge, in IDLE) and push the expected trace.
  task automatic start(input int g);
    int n;
    int steps;
    rec_t r;
    n = cyc;
    iter_cnt[g] = 0;
    beg[g] = 1'b1;
    r = '{g, 0, 1};
    sb.push_back(r);
    steps = 0;
    for (int i = 1; i <= n_of(g); i++) begin
      r = '{g, 0, 32 + i};
      sb.push_back(r);
      steps++;
      if (i == 4 || (i == 13 && n_of(g) >= 13)) begin
        sb.push_back(r);
        steps++;
      end
    end
    r = '{g, 1, n + 2 + steps};
    sb.push_back(r);
    r = '{g, 2, n + 3 + steps};
    sb.push_back(r);
    @(posedge clk);
    #1 beg[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    for (int i = 0; i < 60; i++) begin
      if (done[g]) break;
      @(posedge clk);
      #1;
    end
    check($sformatf("done_reached[%0d]", g), int'(done[g]), 1);
  endtask

  task automatic do_ack(input int g);
    ack[g] = 1'b1;
    @(posedge clk);
    #1 ack[g] = 1'b0;
    check($sformatf("ready_after_ack[%0d]", g), int'(ready[g]), 1);
    check($sformatf("done_after_ack[%0d]", g), int'(done[g]), 0);
  endtask

  task automatic check_reset_vals(input int g);
    check($sformatf("rst_ready[%0d]", g), int'(ready[g]), 1);
    check($sformatf("rst_done[%0d]", g), int'(done[g]), 0);
    check($sformatf("rst_load_en[%0d]", g), int'(load_en[g]), 0);
    check($sformatf("rst_out_en[%0d]", g), int'(out_en[g]), 0);
    check($sformatf("rst_mux_sel[%0d]", g), int'(mux_sel[g]), 0);
    check($sformatf("rst_iter_idx[%0d]", g), int'(iter_idx[g]), 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    done_prev = 3'b000;
    for (int g = 0; g < 3; g++) iter_cnt[g] = 0;
    rst = 1'b1;
    beg = 3'b000;
    ack = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 3; g++) check_reset_vals(g);

    // Nominal run, then hold in DONE for 10 cycles without ack.
    start(0);
    wait_done(0);
    check("iter_len_15", iter_cnt[0], 17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", int'(done[0]), 1);
      check("hold_load_en", int'(load_en[0]), 0);
      check("hold_out_en", int'(out_en[0]), 0);
      check("hold_iter_idx", int'(iter_idx[0]), 0);
      check("hold_ready", int'(ready[0]), 0);
    end
    do_ack(0);

    // beg and ack pulsed mid-ITER must not perturb the run or queue a new one.
    @(posedge clk);
    #1 start(0);
    repeat (4) @(posedge clk);
    #1 beg[0] = 1'b1;
    @(posedge clk);
    #1 beg[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 ack[0] = 1'b1;
    @(posedge clk);
    #1 ack[0] = 1'b0;
    wait_done(0);
    check("iter_len_ignored", iter_cnt[0], 17);
    do_ack(0);
    repeat (3) @(posedge clk);
    #1 check("no_queued_beg", int'(ready[0]), 1);

    // Reset while iter_idx is 7; the rest of that run must never appear.
    start(0);
    for (int i = 0; i < 30; i++) begin
      if (iter_idx[0] == 5'd7) break;
      @(posedge clk);
      #1;
    end
    check("reached_idx7", int'(iter_idx[0]), 7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].inst == 0) sb.delete(i);
    end
    check_reset_vals(0);
    repeat (25) @(posedge clk);
    #1 check("no_done_after_rst", int'(done[0]), 0);
    start(0);
    wait_done(0);
    check("iter_len_after_rst", iter_cnt[0], 17);

    // beg with ack in DONE returns to IDLE without starting; next-cycle beg starts a run.
    beg[0] = 1'b1;
    ack[0] = 1'b1;
    @(posedge clk);
    #1 beg[0] = 1'b0;
    ack[0] = 1'b0;
    check("beg_ack_ready", int'(ready[0]), 1);
    check("beg_ack_no_load", int'(load_en[0]), 0);
    start(0);
    wait_done(0);
    check("iter_len_restart", iter_cnt[0], 17);
    do_ack(0);

    // Shorter iteration counts.
    start(1);
    wait_done(1);
    check("iter_len_4", iter_cnt[1], 5);
    do_ack(1);
    start(2);
    wait_done(2);
    check("iter_len_12", iter_cnt[2], 13);
    do_ack(2);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
